requant_writeback: RTL and testbench

//  Drains the int32 accumulator tile that the systolic array writes into the C buffer, one row per cycle,
//  and requantizes every lane to int8 using the TFLite per-tensor rule: bias, fixed-point multiply, rounding shift, offset, clamp.

---
 rtl/requant_writeback_pkg.sv | 44 ++++
 rtl/requant_writeback_lane.sv | 77 +++++++
 rtl/requant_writeback.sv | 141 ++++++++++++++
 tb/tb_requant_writeback.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/requant_writeback_pkg.sv
// Shared definitions for the requantizing write-back block: FSM states, int32 limits,
// pipeline latency and helpers that turn the signed shift into capped left/right amounts.
package requant_writeback_pkg;

    typedef enum logic [1:0] {
        STATE_IDLE  = 2'd0,
        STATE_READ  = 2'd1,
        STATE_DRAIN = 2'd2
    } state_t;

    localparam logic [31:0] INT32_MIN = 32'h8000_0000;
    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam int          PIPE_LAT  = 5;

    localparam logic signed [63:0] NUDGE_POS = 64'sh0000_0000_4000_0000;
    localparam logic signed [63:0] NUDGE_NEG = 64'shFFFF_FFFF_C000_0001;

    function automatic logic [4:0] left_amt(input logic [7:0] sh);
        logic [4:0] amt;
        if (sh[7] == 1'b0 && sh > 8'd31) begin
            amt = 5'd31;
        end else if (sh[7] == 1'b0) begin
            amt = sh[4:0];
        end else begin
            amt = 5'd0;
        end
        return amt;
    endfunction

    function automatic logic [4:0] right_amt(input logic [7:0] sh);
        logic [8:0] mag;
        logic [4:0] amt;
        mag = 9'd0 - {sh[7], sh};
        if (sh[7] == 1'b0) begin
            amt = 5'd0;
        end else if (mag > 9'd31) begin
            amt = 5'd31;
        end else begin
            amt = mag[4:0];
        end
        return amt;
    endfunction

endpackage

// File: rtl/requant_writeback_lane.sv
// One int32 -> int8 requantization lane: bias + left shift, 64-bit product,
// saturating doubling-high-mul, rounding right shift with offset and clamp.
module requant_writeback_lane
    import requant_writeback_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] acc,
    input  logic [31:0] bias,
    input  logic [31:0] q_mult,
    input  logic [4:0]  lsh,
    input  logic [4:0]  rsh,
    input  logic [31:0] out_offset,
    input  logic [7:0]  act_min,
    input  logic [7:0]  act_max,
    output logic [7:0]  q
);

    logic [31:0]        x_s, x_r;
    logic signed [63:0] p_s, p_r;
    logic               sat_s, sat_r;
    logic signed [63:0] sum_s, div_s;
    logic [31:0]        y_s, y_r;
    logic [31:0]        mask_s, rem_s, thr_s, z_s;
    logic signed [31:0] ysh_s;
    logic signed [32:0] w_s, lo_s, hi_s;
    logic [7:0]         q_s;
    logic [31:0]        unused_hi_s;

    // Per-stage arithmetic feeding the four pipeline registers.
    always_comb begin
        x_s   = (acc + bias) << lsh;
        p_s   = $signed({{32{x_r[31]}}, x_r}) * $signed({{32{q_mult[31]}}, q_mult});
        sat_s = (x_r == INT32_MIN) && (q_mult == INT32_MIN);

        sum_s = p_r + (p_r[63] ? NUDGE_NEG : NUDGE_POS);
        // Division by 2^31 must truncate toward zero, so bias negatives before the shift.
        div_s = sum_s[63] ? ((sum_s + 64'sh0000_0000_7FFF_FFFF) >>> 31) : (sum_s >>> 31);
        y_s   = sat_r ? INT32_MAX : div_s[31:0];
        unused_hi_s = div_s[63:32];

        mask_s = (32'd1 << rsh) - 32'd1;
        rem_s  = y_r & mask_s;
        thr_s  = (mask_s >> 1) + {31'd0, y_r[31]};
        ysh_s  = $signed(y_r) >>> rsh;
        z_s    = ysh_s + {31'd0, (rem_s > thr_s)};

        w_s  = $signed({z_s[31], z_s}) + $signed({out_offset[31], out_offset});
        lo_s = $signed({{25{act_min[7]}}, act_min});
        hi_s = $signed({{25{act_max[7]}}, act_max});
        if (w_s < lo_s) begin
            q_s = act_min;
        end else if (w_s > hi_s) begin
            q_s = act_max;
        end else begin
            q_s = w_s[7:0];
        end
    end

    // Pipeline registers: shifted sum, product, SRDHM result, clamped int8.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_r   <= 32'd0;
            p_r   <= 64'sd0;
            sat_r <= 1'b0;
            y_r   <= 32'd0;
            q     <= 8'd0;
        end else begin
            x_r   <= x_s;
            p_r   <= p_s;
            sat_r <= sat_s;
            y_r   <= y_s;
            q     <= q_s;
        end
    end

endmodule

// File: rtl/requant_writeback.sv
// Drains an int32 accumulator tile row by row from the C buffer, requantizes each lane
// to int8 and writes packed rows to the output buffer after a fixed pipeline latency.
module requant_writeback
    import requant_writeback_pkg::*;
#(
    parameter int C_depth = 2,
    parameter int O_depth = 14,
    parameter int ar_size = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    output logic                    busy,
    input  logic [2:0]              num_rows,
    input  logic [O_depth-1:0]      O_base,
    input  logic [32*ar_size-1:0]   bias_data,
    input  logic [31:0]             q_mult,
    input  logic [7:0]              q_shift,
    input  logic [31:0]             out_offset,
    input  logic [7:0]              act_min,
    input  logic [7:0]              act_max,
    output logic [C_depth-1:0]      C_index,
    input  logic [32*ar_size-1:0]   C_data,
    output logic [O_depth-1:0]      O_index,
    output logic [8*ar_size-1:0]    O_data,
    output logic                    O_wr_en
);

    state_t                  state_r, state_s;
    logic                    start_s, last_row_s;
    logic [2:0]              num_rows_r;
    logic [O_depth-1:0]      base_r;
    logic [32*ar_size-1:0]   bias_r;
    logic [31:0]             mult_r, offset_r;
    logic [4:0]              lsh_r, rsh_r;
    logic [7:0]              min_r, max_r;
    logic [PIPE_LAT-1:0]     vld_r;
    logic [O_depth-1:0]      idx_r [PIPE_LAT];

    assign last_row_s = (3'(C_index) == num_rows_r - 3'd1);
    assign busy       = (state_r != STATE_IDLE) || enable;
    assign O_wr_en    = vld_r[PIPE_LAT-1];
    assign O_index    = idx_r[PIPE_LAT-1];

    // Next-state logic; enable only matters in IDLE.
    always_comb begin
        state_s = state_r;
        start_s = 1'b0;
        case (state_r)
            STATE_IDLE: begin
                if (enable) begin
                    start_s = 1'b1;
                    if (num_rows == 3'd0) begin
                        state_s = STATE_DRAIN;
                    end else begin
                        state_s = STATE_READ;
                    end
                end else begin
                    state_s = STATE_IDLE;
                end
            end
            STATE_READ: begin
                if (last_row_s) begin
                    state_s = STATE_DRAIN;
                end else begin
                    state_s = STATE_READ;
                end
            end
            STATE_DRAIN: begin
                // The row in the final stage is already on the outputs this cycle.
                if (vld_r[PIPE_LAT-2:0] == {(PIPE_LAT-1){1'b0}}) begin
                    state_s = STATE_IDLE;
                end else begin
                    state_s = STATE_DRAIN;
                end
            end
            default: state_s = STATE_IDLE;
        endcase
    end

    // State, row counter, config latch and the valid/address pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= STATE_IDLE;
            C_index    <= {C_depth{1'b0}};
            num_rows_r <= 3'd0;
            base_r     <= {O_depth{1'b0}};
            bias_r     <= {(32*ar_size){1'b0}};
            mult_r     <= 32'd0;
            offset_r   <= 32'd0;
            lsh_r      <= 5'd0;
            rsh_r      <= 5'd0;
            min_r      <= 8'd0;
            max_r      <= 8'd0;
            vld_r      <= {PIPE_LAT{1'b0}};
            for (int i = 0; i < PIPE_LAT; i++) begin
                idx_r[i] <= {O_depth{1'b0}};
            end
        end else begin
            state_r <= state_s;
            if (start_s) begin
                num_rows_r <= num_rows;
                base_r     <= O_base;
                bias_r     <= bias_data;
                mult_r     <= q_mult;
                offset_r   <= out_offset;
                lsh_r      <= left_amt(q_shift);
                rsh_r      <= right_amt(q_shift);
                min_r      <= act_min;
                max_r      <= act_max;
            end
            if (state_r == STATE_READ && !last_row_s) begin
                C_index <= C_index + C_depth'(1);
            end else begin
                C_index <= {C_depth{1'b0}};
            end
            vld_r    <= {vld_r[PIPE_LAT-2:0], (state_r == STATE_READ)};
            idx_r[0] <= base_r + O_depth'(C_index);
            for (int i = 1; i < PIPE_LAT; i++) begin
                idx_r[i] <= idx_r[i-1];
            end
        end
    end

    for (genvar g = 0; g < ar_size; g++) begin : g_lane
        requant_writeback_lane u_lane (
            .clk        (clk),
            .rst        (rst),
            .acc        (C_data[32*g +: 32]),
            .bias       (bias_r[32*g +: 32]),
            .q_mult     (mult_r),
            .lsh        (lsh_r),
            .rsh        (rsh_r),
            .out_offset (offset_r),
            .act_min    (min_r),
            .act_max    (max_r),
            .q          (O_data[8*g +: 8])
        );
    end

endmodule

// File: tb/tb_requant_writeback.sv
// Directed bench for requant_writeback: an arithmetic reference model plus a per-cycle
// scoreboard of expected C_index, busy and output writes, with literal spot checks.
module tb_requant_writeback;

    logic         clk = 1'b0;
    logic         rst, enable, busy, O_wr_en;
    logic [2:0]   num_rows;
    logic [13:0]  O_base, O_index;
    logic [127:0] bias_data, C_data;
    logic [31:0]  q_mult, out_offset, O_data;
    logic [7:0]   q_shift, act_min, act_max;
    logic [1:0]   C_index;

    requant_writeback dut (
        .clk(clk), .rst(rst), .enable(enable), .busy(busy), .num_rows(num_rows),
        .O_base(O_base), .bias_data(bias_data), .q_mult(q_mult), .q_shift(q_shift),
        .out_offset(out_offset), .act_min(act_min), .act_max(act_max),
        .C_index(C_index), .C_data(C_data), .O_index(O_index), .O_data(O_data),
        .O_wr_en(O_wr_en)
    );

    always #5 clk = ~clk;

    logic [127:0] c_mem [4];
    always @(posedge clk) C_data <= c_mem[C_index];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;
    int last_s;

    bit          exp_we   [int];
    bit          exp_busy [int];
    logic [1:0]  exp_ci   [int];
    logic [13:0] exp_idx  [int];
    logic [31:0] exp_dat  [int];
    int          log_cyc [$];
    logic [13:0] log_idx [$];
    logic [31:0] log_dat [$];

    int         cfg_bias [4];
    int         cfg_mult, cfg_off;
    logic [7:0] cfg_shift, cfg_min, cfg_max;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, act, want);
        end
    endtask

    // TFLite requantization of one lane using plain 64-bit integer arithmetic.
    function automatic logic [7:0] ref_lane(input int acc, input int bias, input int m,
                                            input int sh, input int off, input int lo, input int hi);
        int x, e;
        longint p, y, d, q, r, w;
        x = acc + bias;
        if (sh > 0) x = x << ((sh > 31) ? 31 : sh);
        if (x == int'(32'h8000_0000) && m == int'(32'h8000_0000)) begin
            y = 64'sd2147483647;
        end else begin
            p = longint'(x) * longint'(m);
            y = (p + ((p >= 0) ? 64'sd1073741824 : -64'sd1073741823)) / 64'sd2147483648;
        end
        e = (sh < 0) ? ((-sh > 31) ? 31 : -sh) : 0;
        d = 64'sd1 <<< e;
        q = y / d;
        r = y - q * d;
        if (2 * ((r < 0) ? -r : r) >= d) q = q + ((y < 0) ? -1 : 1);
        w = q + longint'(off);
        if (w < lo) w = lo;
        else if (w > hi) w = hi;
        return w[7:0];
    endfunction

    function automatic logic [31:0] row_exp(input int r);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            v[8*i +: 8] = ref_lane(int'(c_mem[r][32*i +: 32]), cfg_bias[i], cfg_mult,
                                   int'($signed(cfg_shift)), cfg_off,
                                   int'($signed(cfg_min)), int'($signed(cfg_max)));
        end
        return v;
    endfunction

    task automatic set_cfg(input logic [31:0] m, input logic [7:0] sh, input logic [31:0] off,
                           input logic [7:0] lo, input logic [7:0] hi);
        cfg_mult = int'(m); cfg_shift = sh; cfg_off = int'(off); cfg_min = lo; cfg_max = hi;
        for (int i = 0; i < 4; i++) cfg_bias[i] = 0;
    endtask

    task automatic set_row(input int r, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        c_mem[r] = {a3, a2, a1, a0};
    endtask

    task automatic purge(input int from);
        for (int k = from; k < from + 32; k++) begin
            if (exp_we.exists(k))   exp_we.delete(k);
            if (exp_busy.exists(k)) exp_busy.delete(k);
            if (exp_ci.exists(k))   exp_ci.delete(k);
        end
    endtask

    task automatic run(input int n, input logic [13:0] base, input bit mid, input int rst_at);
        int s, last;
        @(posedge clk); #1;
        s = cyc;
        last_s = s;
        num_rows = 3'(n); O_base = base; q_mult = cfg_mult; q_shift = cfg_shift;
        out_offset = cfg_off; act_min = cfg_min; act_max = cfg_max;
        for (int i = 0; i < 4; i++) bias_data[32*i +: 32] = cfg_bias[i];
        enable = 1'b1;
        for (int r = 0; r < n; r++) begin
            exp_ci[s+1+r]  = 2'(r);
            exp_we[s+6+r]  = 1'b1;
            exp_idx[s+6+r] = base + 14'(r);
            exp_dat[s+6+r] = row_exp(r);
        end
        last = (n > 0) ? s + n + 5 : s + 1;
        for (int k = s; k <= last; k++) exp_busy[k] = 1'b1;
        log_cyc.delete(); log_idx.delete(); log_dat.delete();
        @(posedge clk); #1;
        enable = 1'b0;
        bias_data = ~bias_data; q_mult = 32'h1234_5678; q_shift = 8'h05;
        out_offset = 32'h55; act_min = 8'h00; act_max = 8'h01; num_rows = 3'd2; O_base = 14'h2AAA;
        if (mid) begin
            @(posedge clk); #1;
            enable = 1'b1; num_rows = 3'd1; O_base = 14'h0200;
            @(posedge clk); #1;
            enable = 1'b0;
        end
        if (rst_at >= 0) begin
            while (cyc < s + rst_at) begin
                @(posedge clk); #1;
            end
            rst = 1'b1;
            purge(s + rst_at + 1);
            @(posedge clk); #1;
            rst = 1'b0;
        end
        repeat (n + 8) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison of DUT outputs against the scoreboard.
    always @(negedge clk) begin
        if (O_wr_en) begin
            log_cyc.push_back(cyc); log_idx.push_back(O_index); log_dat.push_back(O_data);
        end
        if (chk_on) begin
            chk("c_index", {62'd0, C_index}, {62'd0, exp_ci.exists(cyc) ? exp_ci[cyc] : 2'd0});
            chk("busy", {63'd0, busy}, {63'd0, exp_busy.exists(cyc)});
            chk("wr_en", {63'd0, O_wr_en}, {63'd0, exp_we.exists(cyc)});
            if (exp_we.exists(cyc)) begin
                chk("o_index", {50'd0, O_index}, {50'd0, exp_idx[cyc]});
                chk("o_data", {32'd0, O_data}, {32'd0, exp_dat[cyc]});
            end
        end
    end

    initial begin
        rst = 1'b1; enable = 1'b0; num_rows = 3'd0; O_base = 14'd0; bias_data = 128'd0;
        q_mult = 32'd0; q_shift = 8'd0; out_offset = 32'd0; act_min = 8'h80; act_max = 8'h7F;
        for (int i = 0; i < 4; i++) c_mem[i] = 128'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_c_index", {62'd0, C_index}, 64'd0);
        chk("rst_o_index", {50'd0, O_index}, 64'd0);
        chk("rst_o_data", {32'd0, O_data}, 64'd0);
        chk("rst_wr_en", {63'd0, O_wr_en}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk_on = 1'b1;

        chk("model_t1", {56'd0, ref_lane(100, 0, 32'h4000_0000, 0, 0, -128, 127)}, 64'h32);
        chk("model_t2", {56'd0, ref_lane(-3, 0, 32'h7FFF_FFFF, -1, 0, -128, 127)}, 64'hFE);
        chk("model_t3", {56'd0, ref_lane(int'(32'h8000_0000), 0, int'(32'h8000_0000), 0, -128, -128, 127)}, 64'h7F);
        chk("model_t4", {56'd0, ref_lane(-1000, 0, 32'h7FFF_FFFF, 0, -5, -128, 127)}, 64'h80);

        set_cfg(32'h4000_0000, 8'd0, 32'd0, 8'h80, 8'h7F);
        set_row(0, 32'd100, -32'sd100, 32'd7, 32'h7FFF_FFFF);
        run(1, 14'h0010, 1'b0, -1);
        chk("t1_lane0", {56'd0, log_dat[0][7:0]}, 64'h32);

        set_cfg(32'h7FFF_FFFF, 8'hFF, 32'd0, 8'h80, 8'h7F);
        set_row(0, -32'sd3, 32'd3, 32'd1000, -32'sd7);
        run(1, 14'h0020, 1'b0, -1);
        chk("t2_lane0", {56'd0, log_dat[0][7:0]}, 64'hFE);

        set_cfg(32'h4000_0000, 8'd2, 32'd0, 8'h80, 8'h7F);
        set_row(0, 32'd3, -32'sd3, 32'h4000_0000, 32'd1);
        run(1, 14'h0030, 1'b0, -1);
        chk("t2b_lane0", {56'd0, log_dat[0][7:0]}, 64'h06);

        set_cfg(32'h8000_0000, 8'd0, -32'sd128, 8'h80, 8'h7F);
        set_row(0, 32'h8000_0000, 32'd0, 32'd1, 32'h7FFF_FFFF);
        run(1, 14'h0040, 1'b0, -1);
        chk("t3_lane0", {56'd0, log_dat[0][7:0]}, 64'h7F);
        chk("t3_lane3", {56'd0, log_dat[0][31:24]}, 64'h80);

        set_cfg(32'h7FFF_FFFF, 8'd0, -32'sd5, 8'h80, 8'h7F);
        set_row(0, 32'd1000, -32'sd1000, 32'd0, 32'd12);
        set_row(1, 32'd20, -32'sd20, 32'd130, -32'sd130);
        run(2, 14'h0050, 1'b0, -1);
        chk("t4_lane0", {56'd0, log_dat[0][7:0]}, 64'h7F);
        chk("t4_lane1", {56'd0, log_dat[0][15:8]}, 64'h80);

        set_cfg(32'h7FFF_FFFF, 8'd0, 32'd0, 8'h80, 8'h7F);
        cfg_bias[0] = 7; cfg_bias[1] = -9; cfg_bias[2] = 200; cfg_bias[3] = -1;
        set_row(0, 32'd0, 32'd0, 32'd0, 32'd0);
        run(1, 14'h0060, 1'b0, -1);
        chk("t4b_bias", {56'd0, log_dat[0][7:0]}, 64'h07);

        set_cfg(32'h5A5A_5A5A, 8'hFD, 32'd10, 8'hEC, 8'd50);
        cfg_bias[0] = 1000; cfg_bias[1] = -2000; cfg_bias[2] = 3; cfg_bias[3] = 400;
        set_row(0, 32'd64, -32'sd64, 32'd300, -32'sd300);
        set_row(1, 32'd5, 32'd17, -32'sd33, 32'd99);
        set_row(2, 32'h0001_0000, -32'sd70000, 32'd8, 32'd0);
        set_row(3, 32'h7FFF_FFF0, 32'h8000_0010, 32'd1, -32'sd1);
        run(4, 14'h0100, 1'b1, -1);
        chk("t5_nwrites", 64'(log_cyc.size()), 64'd4);
        chk("t5_first_lat", 64'(log_cyc[0] - last_s), 64'd6);
        for (int r = 0; r < 4; r++) chk("t5_addr", {50'd0, log_idx[r]}, 64'h100 + 64'(r));

        set_cfg(32'h4000_0000, 8'd100, 32'd0, 8'h80, 8'h7F);
        set_row(0, 32'd1, 32'd2, 32'd0, -32'sd1);
        set_row(1, 32'd0, 32'd3, 32'd4, 32'd5);
        set_row(2, -32'sd2, 32'd1, 32'd1, 32'd1);
        set_row(3, 32'd7, 32'd0, 32'd0, 32'd0);
        run(4, 14'h3FFE, 1'b0, -1);
        chk("wrap_addr", {50'd0, log_idx[2]}, 64'h0000);

        set_cfg(32'h7FFF_FFFF, 8'h80, 32'd0, 8'h80, 8'h7F);
        set_row(0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd5, -32'sd5);
        run(1, 14'h0070, 1'b0, -1);
        chk("cap_rshift", {56'd0, log_dat[0][7:0]}, 64'h01);

        set_cfg(32'h4000_0000, 8'd0, 32'd0, 8'h80, 8'h7F);
        run(4, 14'h0080, 1'b0, 2);
        chk("rst_nwrites", 64'(log_cyc.size()), 64'd0);

        run(0, 14'h0090, 1'b0, -1);
        chk("zero_nwrites", 64'(log_cyc.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
